// File: rtl/inc_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit incrementer among four requesters.
// Two-state sequencer: grant and capture in IDLE, increment and complete in BUSY.

module inc_arbiter_inc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   assign {carry_o, sum_o} = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};

endmodule

module inc_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [3:0]           Req,
   input  logic [4*WIDTH-1:0]   A_in,
   output logic [3:0]           Gnt,
   output logic [3:0]           Done,
   output logic [WIDTH-1:0]     D_out,
   output logic                 Ovf,
   output logic                 Busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       owner_q, owner_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [3:0]       done_q, done_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] opnd [4];
   logic [WIDTH-1:0] inc_sum;
   logic             inc_carry;
   logic             win_found;
   logic [1:0]       win_idx;
   logic [1:0]       cand;

   for (genvar g = 0; g < 4; g++) begin : g_opnd
      assign opnd[g] = A_in[g*WIDTH +: WIDTH];
   end

   inc_arbiter_inc #(.WIDTH(WIDTH)) u_inc (
      .a_i     (op_q),
      .sum_o   (inc_sum),
      .carry_o (inc_carry)
   );

   // First requester at or after ptr_q, wrapping mod 4.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_found && Req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      op_d    = op_q;
      dout_d  = dout_q;
      gnt_d   = '0;
      done_d  = '0;
      ovf_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               op_d    = opnd[win_idx];
               owner_d = win_idx;
               gnt_d   = 4'b0001 << win_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            dout_d  = inc_sum;
            ovf_d   = inc_carry;
            done_d  = 4'b0001 << owner_q;
            ptr_d   = owner_q + 2'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         op_q    <= '0;
         dout_q  <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         dout_q  <= dout_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Gnt   = gnt_q;
   assign Done  = done_q;
   assign D_out = dout_q;
   assign Ovf   = ovf_q;
   assign Busy  = (state_q == BUSY);

endmodule
